// File: rtl/layer_sequencer.sv
// ---------------------------------------------------------------------------
// layer_sequencer
//
// Per-inference controller for the dense-layer datapath. For each of
// NUM_LAYERS layers it clears the MAC accumulators, feeds the layer's input
// columns, waits out the MAC pipeline, triggers the activation block, waits
// for its completion and writes the activation result back into the feature
// buffer. A sticky error is raised if the activation block does not answer
// within ACT_TIMEOUT cycles.
//
// Ports:
//   clk            system clock, rising edge
//   rst_overall_n  asynchronous active-low reset
//   start          begin inference (sampled only while idle)
//   abort          synchronous abort back to idle
//   act_done       activation complete from relu_block
//   busy           high whenever the sequencer is not idle
//   done           one-cycle pulse when an inference completes
//   err            sticky activation-timeout flag
//   layer_idx      current layer number
//   last_layer     current layer is the final one
//   col_addr       weight/feature column address during column feed
//   mac_en         MAC accumulate enable
//   rst_vals       accumulator/activation clear
//   layer_done     one-cycle activation trigger to relu_block
//   buf_load       one-cycle feature-buffer write strobe
// ---------------------------------------------------------------------------
module layer_sequencer #(
   parameter int NUM_LAYERS = 3,
   parameter int COL_W = 10,
   parameter logic [NUM_LAYERS*COL_W-1:0] LAYER_COLS = {10'd32, 10'd64, 10'd784},
   parameter int PIPE_LAT = 2,
   parameter int ACT_TIMEOUT = 8,
   parameter int LAYER_W = 2
) (
   input  logic               clk,
   input  logic               rst_overall_n,
   input  logic               start,
   input  logic               abort,
   input  logic               act_done,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [LAYER_W-1:0] layer_idx,
   output logic               last_layer,
   output logic [COL_W-1:0]   col_addr,
   output logic               mac_en,
   output logic               rst_vals,
   output logic               layer_done,
   output logic               buf_load
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FEED,
      S_DRAIN,
      S_ACT,
      S_WAIT_ACT,
      S_LOAD,
      S_FINISH
   } state_e;

   // One counter is shared between the drain delay and the activation
   // timeout; it must be wide enough for the larger of the two.
   localparam int CNT_MAX = (PIPE_LAT > ACT_TIMEOUT) ? PIPE_LAT : ACT_TIMEOUT;
   localparam int CNT_W = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(ACT_TIMEOUT - 1);
   localparam logic [LAYER_W-1:0] LAST_IDX = LAYER_W'(NUM_LAYERS - 1);

   // With no pipeline latency the drain state is skipped altogether.
   localparam state_e AFTER_FEED = (PIPE_LAT == 0) ? S_ACT : S_DRAIN;

   state_e             r_state;
   logic [LAYER_W-1:0] r_layerIdx;
   logic [COL_W-1:0]   r_colAddr;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_err;

   logic [COL_W-1:0]   w_layerCols;
   logic [COL_W-1:0]   w_lastCol;
   logic               w_lastLayer;

   // Column count for the layer in progress; layer 0 sits in the LSBs.
   assign w_layerCols = LAYER_COLS[int'(r_layerIdx)*COL_W +: COL_W];
   assign w_lastCol   = w_layerCols - COL_W'(1);
   assign w_lastLayer = (r_layerIdx == LAST_IDX);

   // Sequencer FSM. Abort out of any active state overrides every other
   // transition; counters are cleared on entry to the state that uses them.
   always_ff @(posedge clk or negedge rst_overall_n) begin
      if (!rst_overall_n) begin
         r_state    <= S_IDLE;
         r_layerIdx <= '0;
         r_colAddr  <= '0;
         r_cnt      <= '0;
         r_err      <= 1'b0;
      end else if (abort && (r_state != S_IDLE)) begin
         r_state   <= S_IDLE;
         r_colAddr <= '0;
         r_cnt     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state    <= S_CLEAR;
                  r_layerIdx <= '0;
                  r_err      <= 1'b0;
               end
            end
            S_CLEAR: begin
               r_colAddr <= '0;
               r_cnt     <= '0;
               // A layer without columns goes straight to the drain.
               if (w_layerCols == '0) begin
                  r_state <= AFTER_FEED;
               end else begin
                  r_state <= S_FEED;
               end
            end
            S_FEED: begin
               if (r_colAddr == w_lastCol) begin
                  r_colAddr <= '0;
                  r_cnt     <= '0;
                  r_state   <= AFTER_FEED;
               end else begin
                  r_colAddr <= r_colAddr + COL_W'(1);
               end
            end
            S_DRAIN: begin
               if (r_cnt == DRAIN_LAST) begin
                  r_cnt   <= '0;
                  r_state <= S_ACT;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_ACT: begin
               r_cnt   <= '0;
               r_state <= S_WAIT_ACT;
            end
            S_WAIT_ACT: begin
               // A completion arriving on the final allowed cycle still wins
               // over the timeout.
               if (act_done) begin
                  r_cnt   <= '0;
                  r_state <= S_LOAD;
               end else if (r_cnt == TO_LAST) begin
                  r_cnt   <= '0;
                  r_err   <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_LOAD: begin
               if (w_lastLayer) begin
                  r_state <= S_FINISH;
               end else begin
                  r_layerIdx <= r_layerIdx + LAYER_W'(1);
                  r_state    <= S_CLEAR;
               end
            end
            S_FINISH: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Moore decode: every strobe is a pure function of the registered state.
   // layer_idx is held after finishing so the last layer stays visible.
   assign busy       = (r_state != S_IDLE);
   assign rst_vals   = (r_state == S_CLEAR);
   assign mac_en     = (r_state == S_FEED);
   assign layer_done = (r_state == S_ACT);
   assign buf_load   = (r_state == S_LOAD);
   assign done       = (r_state == S_FINISH);
   assign err        = r_err;
   assign layer_idx  = r_layerIdx;
   assign last_layer = w_lastLayer;
   assign col_addr   = r_colAddr;

endmodule

// File: tb/tb_layer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_layer_sequencer
//
// Directed bench for layer_sequencer. The main instance runs two layers of
// 3 and 4 columns with a 2-cycle drain; a second instance has an empty
// first layer and no drain latency. Expected values are written out per
// cycle by hand, with cycle 0 being the cycle in which start is presented.
// ---------------------------------------------------------------------------
module tb_layer_sequencer;

   logic       clk = 1'b0;
   logic       rstN;
   logic       start;
   logic       abort;
   logic       actDone;
   logic       busy, done, err, lastLayer, macEn, rstVals, layerDone, bufLoad;
   logic [1:0] layerIdx;
   logic [9:0] colAddr;

   logic       zStart;
   logic       zActDone;
   logic       zBusy, zDone, zErr, zLastLayer, zMacEn, zRstVals, zLayerDone, zBufLoad;
   logic [1:0] zLayerIdx;
   logic [9:0] zColAddr;

   int checks = 0;
   int failures = 0;
   int doneCount;
   int rstCount;
   int loadCount;

   always #5 clk = ~clk;

   layer_sequencer #(
      .NUM_LAYERS(2), .COL_W(10), .LAYER_COLS({10'd4, 10'd3}),
      .PIPE_LAT(2), .ACT_TIMEOUT(8), .LAYER_W(2)
   ) dut (
      .clk(clk), .rst_overall_n(rstN), .start(start), .abort(abort),
      .act_done(actDone), .busy(busy), .done(done), .err(err),
      .layer_idx(layerIdx), .last_layer(lastLayer), .col_addr(colAddr),
      .mac_en(macEn), .rst_vals(rstVals), .layer_done(layerDone),
      .buf_load(bufLoad)
   );

   layer_sequencer #(
      .NUM_LAYERS(2), .COL_W(10), .LAYER_COLS({10'd2, 10'd0}),
      .PIPE_LAT(0), .ACT_TIMEOUT(8), .LAYER_W(2)
   ) dutZ (
      .clk(clk), .rst_overall_n(rstN), .start(zStart), .abort(1'b0),
      .act_done(zActDone), .busy(zBusy), .done(zDone), .err(zErr),
      .layer_idx(zLayerIdx), .last_layer(zLastLayer), .col_addr(zColAddr),
      .mac_en(zMacEn), .rst_vals(zRstVals), .layer_done(zLayerDone),
      .buf_load(zBufLoad)
   );

   task automatic applyStimulus(input logic s, input logic a, input logic d);
      start   = s;
      abort   = a;
      actDone = d;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Advance to the middle (falling edge) of the next cycle.
   task automatic nextCycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkAllZero(input string where);
      checkOutput({where, ":busy"}, busy, 0);
      checkOutput({where, ":mac_en"}, macEn, 0);
      checkOutput({where, ":col_addr"}, colAddr, 0);
      checkOutput({where, ":layer_idx"}, layerIdx, 0);
      checkOutput({where, ":rst_vals"}, rstVals, 0);
      checkOutput({where, ":layer_done"}, layerDone, 0);
      checkOutput({where, ":buf_load"}, bufLoad, 0);
      checkOutput({where, ":done"}, done, 0);
      checkOutput({where, ":err"}, err, 0);
      checkOutput({where, ":last_layer"}, lastLayer, 0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rstN = 1'b0;
      zStart = 1'b0;
      zActDone = 1'b0;
      applyStimulus(0, 0, 0);
      #12;
      checkAllZero("reset");
      @(negedge clk);
      rstN = 1'b1;
      nextCycle();

      // Run 1: nominal two-layer inference, act_done one cycle after trigger.
      applyStimulus(1, 0, 0);
      for (int k = 1; k <= 21; k++) begin
         nextCycle();
         checkOutput($sformatf("n_busy@%0d", k), busy, (k >= 1 && k <= 20));
         checkOutput($sformatf("n_rst_vals@%0d", k), rstVals, (k == 1 || k == 10));
         checkOutput($sformatf("n_mac_en@%0d", k), macEn,
                     ((k >= 2 && k <= 4) || (k >= 11 && k <= 14)));
         checkOutput($sformatf("n_col_addr@%0d", k), colAddr,
                     (k >= 2 && k <= 4) ? k - 2 : ((k >= 11 && k <= 14) ? k - 11 : 0));
         checkOutput($sformatf("n_layer_done@%0d", k), layerDone, (k == 7 || k == 17));
         checkOutput($sformatf("n_buf_load@%0d", k), bufLoad, (k == 9 || k == 19));
         checkOutput($sformatf("n_done@%0d", k), done, (k == 20));
         checkOutput($sformatf("n_layer_idx@%0d", k), layerIdx, (k >= 10) ? 1 : 0);
         checkOutput($sformatf("n_last_layer@%0d", k), lastLayer, (k >= 10));
         checkOutput($sformatf("n_err@%0d", k), err, 0);
         applyStimulus(0, 0, (k == 8 || k == 18));
      end

      // Run 2: start held high during the run must not restart or double-fire.
      doneCount = 0;
      rstCount = 0;
      applyStimulus(1, 0, 0);
      for (int k = 1; k <= 22; k++) begin
         nextCycle();
         if (done) doneCount++;
         if (rstVals) rstCount++;
         applyStimulus(k <= 20, 0, (k == 8 || k == 18));
      end
      checkOutput("hold_done_count", doneCount, 1);
      checkOutput("hold_clear_count", rstCount, 2);
      checkOutput("hold_busy_after", busy, 0);

      // Run 3: act_done withheld, timeout after 8 waiting cycles (8..15).
      doneCount = 0;
      loadCount = 0;
      applyStimulus(1, 0, 0);
      for (int k = 1; k <= 17; k++) begin
         nextCycle();
         if (done) doneCount++;
         if (bufLoad) loadCount++;
         if (k == 15) begin
            checkOutput("to_busy@15", busy, 1);
            checkOutput("to_err@15", err, 0);
         end
         if (k == 16) begin
            checkOutput("to_busy@16", busy, 0);
            checkOutput("to_err@16", err, 1);
         end
         applyStimulus(0, 0, 0);
      end
      checkOutput("to_done_count", doneCount, 0);
      checkOutput("to_load_count", loadCount, 0);

      // Abort while idle leaves the sticky error untouched.
      applyStimulus(0, 1, 0);
      nextCycle();
      checkOutput("idle_abort_err", err, 1);
      checkOutput("idle_abort_busy", busy, 0);

      // Run 4: new start clears err; act_done on the last allowed wait cycle
      // still loads; then abort during layer-1 feed.
      applyStimulus(1, 0, 0);
      for (int k = 1; k <= 21; k++) begin
         nextCycle();
         if (k == 1) begin
            checkOutput("b_err@1", err, 0);
            checkOutput("b_rst_vals@1", rstVals, 1);
         end
         if (k == 16) begin
            checkOutput("b_buf_load@16", bufLoad, 1);
            checkOutput("b_err@16", err, 0);
         end
         if (k == 17) begin
            checkOutput("b_rst_vals@17", rstVals, 1);
            checkOutput("b_layer_idx@17", layerIdx, 1);
         end
         if (k == 19) begin
            checkOutput("b_mac_en@19", macEn, 1);
            checkOutput("b_col_addr@19", colAddr, 1);
         end
         if (k == 20) begin
            checkOutput("ab_busy@20", busy, 0);
            checkOutput("ab_mac_en@20", macEn, 0);
            checkOutput("ab_col_addr@20", colAddr, 0);
            checkOutput("ab_done@20", done, 0);
            checkOutput("ab_err@20", err, 0);
         end
         if (k == 21) begin
            checkOutput("ab_busy@21", busy, 0);
            checkOutput("ab_done@21", done, 0);
         end
         applyStimulus((k == 19), (k == 19), (k == 15));
      end

      // Run 5: asynchronous reset in the middle of layer-1 feed.
      applyStimulus(1, 0, 0);
      for (int k = 1; k <= 12; k++) begin
         nextCycle();
         applyStimulus(0, 0, (k == 8));
      end
      checkOutput("pre_rst_mac_en", macEn, 1);
      checkOutput("pre_rst_col_addr", colAddr, 1);
      checkOutput("pre_rst_layer_idx", layerIdx, 1);
      #2;
      rstN = 1'b0;
      #1;
      checkAllZero("async_rst");
      @(negedge clk);
      rstN = 1'b1;
      nextCycle();
      checkOutput("post_rst_busy", busy, 0);

      // Run 6: empty first layer and zero drain latency on the second instance.
      zStart = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         nextCycle();
         checkOutput($sformatf("z_mac_en@%0d", k), zMacEn, (k == 6 || k == 7));
         checkOutput($sformatf("z_rst_vals@%0d", k), zRstVals, (k == 1 || k == 5));
         checkOutput($sformatf("z_layer_done@%0d", k), zLayerDone, (k == 2 || k == 8));
         checkOutput($sformatf("z_buf_load@%0d", k), zBufLoad, (k == 4 || k == 10));
         checkOutput($sformatf("z_done@%0d", k), zDone, (k == 11));
         checkOutput($sformatf("z_busy@%0d", k), zBusy, (k >= 1 && k <= 11));
         zStart = 1'b0;
         zActDone = (k == 3 || k == 9);
      end
      checkOutput("z_err", zErr, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
Per-inference controller that sequences the dense-layer datapath: MAC accumulator clear, column feed, pipeline drain, ReLU activation trigger and feature-buffer write-back, repeated for NUM_LAYERS layers. Sits between the top-level start/done handshake and the MAC array, weight memory and relu_block. Drives relu_block's rst_vals and layer_done inputs and consumes its done output as act_done.

Parameters:
NUM_LAYERS, 3, number of layers sequenced per inference (>=1)
COL_W, 10, width of column counter and of each per-layer column count
LAYER_COLS, {10'd32,10'd64,10'd784}, packed per-layer input column counts; layer 0 in LSBs, COL_W bits each
PIPE_LAT, 2, MAC pipeline drain cycles after last column (>=0)
ACT_TIMEOUT, 8, max cycles spent in WAIT_ACT before error (>=1)
LAYER_W, 2, width of layer_idx (>= clog2(NUM_LAYERS))

Ports:
clk  in  1  system clock, rising edge
rst_overall_n  in  1  asynchronous active-low reset
start  in  1  begin inference; sampled only in IDLE
abort  in  1  synchronous abort; any non-IDLE state -> IDLE next edge
act_done  in  1  activation complete (relu_block done)
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse, inference completed
err  out  1  sticky ACT timeout flag; cleared by next accepted start or reset
layer_idx  out  LAYER_W  current layer number
last_layer  out  1  layer_idx == NUM_LAYERS-1
col_addr  out  COL_W  weight/feature column address during FEED
mac_en  out  1  MAC accumulate enable
rst_vals  out  1  accumulator/activation clear, to relu_block and MAC
layer_done  out  1  one-cycle activation trigger to relu_block
buf_load  out  1  one-cycle write of activation output into feature buffer

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; layer_idx 0, col_addr 0, err 0.
- Moore outputs, registered state; all outputs decoded from state/counters.
- IDLE: start=1 -> CLEAR, layer_idx<=0, err<=0. start while busy ignored.
- CLEAR (1 cycle): rst_vals=1. -> FEED, or DRAIN if LAYER_COLS[layer_idx]==0.
- FEED: mac_en=1, col_addr counts 0..cols-1, one per cycle; after col_addr==cols-1 -> DRAIN, col_addr<=0.
- DRAIN: PIPE_LAT cycles, mac_en=0; PIPE_LAT==0 -> ACT directly.
- ACT (1 cycle): layer_done=1. -> WAIT_ACT, timeout counter<=0.
- WAIT_ACT: act_done=1 -> LOAD. Counter increments per cycle; counter==ACT_TIMEOUT-1 with act_done=0 -> IDLE, err<=1, no done pulse. act_done in any other state ignored.
- LOAD (1 cycle): buf_load=1. last_layer -> FINISH; else layer_idx++ -> CLEAR.
- FINISH (1 cycle): done=1 -> IDLE; layer_idx held until next start.
- abort has priority over all transitions, including start in the same cycle it takes effect; abort in IDLE ignored; no done, err unchanged.
- Reset mid-operation: immediate return to reset values, no pulses emitted.
- Per-layer cycle count = 1 + cols + PIPE_LAT + 1 + (WAIT_ACT cycles) + 1.

Test Plan:
- NUM_LAYERS=2, LAYER_COLS={4,3}, PIPE_LAT=2; start at cycle 0, act_done returned 1 cycle after each layer_done -> rst_vals at cycles 1,10; mac_en cycles 2-4 (col_addr 0,1,2) and 11-14 (col_addr 0..3); layer_done at 7,17; buf_load at 9,19; done at 20 only; busy 1-20.
- Same config, act_done withheld, ACT_TIMEOUT=8 -> err=1 and busy=0 after 8 WAIT_ACT cycles, no buf_load/done; next start clears err and runs normally.
- LAYER_COLS layer0=0, PIPE_LAT=0 -> CLEAR then ACT next cycle, mac_en never asserted for layer 0.
- start asserted every cycle during run -> exactly one done pulse, no restart until IDLE.
- abort during FEED of layer 1 -> IDLE next cycle, mac_en=0, no done, err=0; rst_overall_n low mid-FEED -> all outputs 0 asynchronously.
- Simultaneous act_done and timeout boundary (act_done on cycle ACT_TIMEOUT-1) -> LOAD taken, err stays 0.
